// File: rtl/pgm_rom_fetch_ctrl.sv
// pgm_rom_fetch_ctrl
// Serves 68000 reads of BIOS/P-ROM space from a small direct-mapped cache of
// 64-bit lines. Misses are fetched from DDRAM through a 4-phase req/ack
// handshake with the 50 MHz SDRAM arbiter. The ack is resynchronised locally.
// The block leaves reset in DRAIN, so a handshake that was still open when
// reset arrived is finished before any new request goes out.
module pgm_rom_fetch_ctrl #(
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             fixed_20m_clk,
  input  logic             reset,
  input  logic             cpu_as_n,
  input  logic             cpu_rw_n,
  input  logic [23:1]      cpu_adr,
  input  logic             rom_sel,
  input  logic             flush,
  output logic             dtack_n,
  output logic [15:0]      dout,
  output logic             req,
  output logic [20:0]      req_addr,
  input  logic             ack_async,
  input  logic [63:0]      line_data,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 21 - IDX_W;  // address bits [23:IDX_W+3]

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_REQ,
    S_ACKLO,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Ack synchroniser
  logic r_ack_meta;
  logic r_ack_s;

  // Cycle bookkeeping
  logic [23:1] r_adr;
  logic        r_abort;
  logic        r_flush_pend;

  // Cache storage
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [63:0]      r_line [LINES];

  // Registered outputs
  logic             r_dtack_n;
  logic [15:0]      r_dout;
  logic             r_req;
  logic [20:0]      r_req_addr;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  // Next-value and strobe wires from the output decoder
  logic        w_dtack_n_nxt;
  logic [15:0] w_dout_nxt;
  logic        w_req_nxt;
  logic [20:0] w_req_addr_nxt;
  logic        w_latch;
  logic        w_hit_inc;
  logic        w_miss_inc;
  logic        w_fill_we;

  // Lookup and fill decode
  logic             w_start;
  logic [IDX_W-1:0] w_cpu_idx;
  logic [TAG_W-1:0] w_cpu_tag;
  logic             w_hit;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_aborted;

  function automatic logic [15:0] word_sel(input logic [63:0] line, input logic [1:0] sel);
    return line[{sel, 4'b0000} +: 16];
  endfunction

  assign w_start    = ~cpu_as_n & rom_sel;
  assign w_cpu_idx  = cpu_adr[IDX_W+2:3];
  assign w_cpu_tag  = cpu_adr[23:IDX_W+3];
  assign w_hit      = r_valid[w_cpu_idx] && (r_tag[w_cpu_idx] == w_cpu_tag);
  assign w_fill_idx = r_adr[IDX_W+2:3];
  assign w_fill_tag = r_adr[23:IDX_W+3];
  // The CPU has given up on this cycle if AS went high at any point after the request.
  assign w_aborted  = r_abort | cpu_as_n;

  // Two-flop synchroniser for the arbiter ack. It resets to 1 so that DRAIN
  // waits for the real ack level instead of trusting a reset value.
  always_ff @(posedge fixed_20m_clk) begin
    if (reset) begin
      r_ack_meta <= 1'b1;
      r_ack_s    <= 1'b1;
    end else begin
      r_ack_meta <= ack_async;
      r_ack_s    <= r_ack_meta;
    end
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order in which the blocks are evaluated.
  always_ff @(posedge fixed_20m_clk) begin
    if (reset) r_state <= S_DRAIN;
    else       r_state <= w_next_state;
  end

  // Next-state decode.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_DRAIN: if (!r_ack_s) w_next_state = S_IDLE;
      S_IDLE: begin
        if (w_start) begin
          if (!cpu_rw_n || w_hit) w_next_state = S_RESP;
          else                    w_next_state = S_REQ;
        end
      end
      S_REQ:   if (r_ack_s) w_next_state = S_ACKLO;
      S_ACKLO: if (!r_ack_s) w_next_state = w_aborted ? S_IDLE : S_RESP;
      S_RESP:  if (cpu_as_n) w_next_state = S_IDLE;
      default: w_next_state = S_DRAIN;
    endcase
  end

  // Output decode: next values of the registered outputs plus cache/counter strobes.
  always_comb begin
    w_dtack_n_nxt  = 1'b1;
    w_dout_nxt     = r_dout;
    w_req_nxt      = 1'b0;
    w_req_addr_nxt = r_req_addr;
    w_latch        = 1'b0;
    w_hit_inc      = 1'b0;
    w_miss_inc     = 1'b0;
    w_fill_we      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_latch = 1'b1;
          if (!cpu_rw_n) begin
            w_dtack_n_nxt = 1'b0;
          end else if (w_hit) begin
            w_dtack_n_nxt = 1'b0;
            w_dout_nxt    = word_sel(r_line[w_cpu_idx], cpu_adr[2:1]);
            w_hit_inc     = 1'b1;
          end else begin
            w_req_nxt      = 1'b1;
            w_req_addr_nxt = cpu_adr[23:3];
            w_miss_inc     = 1'b1;
          end
        end
      end
      S_REQ: begin
        w_req_nxt = ~r_ack_s;
        if (r_ack_s) begin
          // A flush seen now or earlier in this fill keeps the line invalid.
          w_fill_we     = ~flush & ~r_flush_pend;
          w_dtack_n_nxt = w_aborted;
          if (!w_aborted) w_dout_nxt = word_sel(line_data, r_adr[2:1]);
        end
      end
      S_ACKLO: w_dtack_n_nxt = w_aborted;
      S_RESP:  w_dtack_n_nxt = cpu_as_n;
      default: ;
    endcase
  end

  // Output registers, address latch, and abort/flush tracking for the current fill.
  always_ff @(posedge fixed_20m_clk) begin
    if (reset) begin
      r_dtack_n    <= 1'b1;
      r_dout       <= 16'hFFFF;
      r_req        <= 1'b0;
      r_req_addr   <= '0;
      r_adr        <= '0;
      r_abort      <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_dtack_n  <= w_dtack_n_nxt;
      r_dout     <= w_dout_nxt;
      r_req      <= w_req_nxt;
      r_req_addr <= w_req_addr_nxt;
      if (w_latch) r_adr <= cpu_adr;
      if (r_state == S_IDLE) begin
        r_abort      <= 1'b0;
        r_flush_pend <= 1'b0;
      end else begin
        if ((r_state == S_REQ || r_state == S_ACKLO) && cpu_as_n) r_abort <= 1'b1;
        if (r_state == S_REQ && flush) r_flush_pend <= 1'b1;
      end
    end
  end

  // Valid bits: reset and flush clear all lines; a fill marks its line valid.
  always_ff @(posedge fixed_20m_clk) begin
    if (reset)          r_valid <= '0;
    else if (flush)     r_valid <= '0;
    else if (w_fill_we) r_valid[w_fill_idx] <= 1'b1;
  end

  // Tag and data storage written on fill.
  // NOTE: tag/data arrays are not reset; the valid bits alone make stale
  // contents unreachable, and leaving them out of reset keeps them plain RAM.
  always_ff @(posedge fixed_20m_clk) begin
    if (w_fill_we) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_line[w_fill_idx] <= line_data;
    end
  end

  // Saturating hit/miss statistics.
  always_ff @(posedge fixed_20m_clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_inc && r_hit_cnt != '1)   r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
      if (w_miss_inc && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign dtack_n    = r_dtack_n;
  assign dout       = r_dout;
  assign req        = r_req;
  assign req_addr   = r_req_addr;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_pgm_rom_fetch_ctrl.sv
// Directed bench for pgm_rom_fetch_ctrl. The bench plays both the 68000 and
// the arbiter, and steps them cycle by cycle against hand-computed timing.
// The counters are instantiated 4 bits wide so that saturation is reachable.
module tb_pgm_rom_fetch_ctrl;

  localparam int TB_CNT_W = 4;

  logic                fixed_20m_clk;
  logic                reset;
  logic                cpu_as_n;
  logic                cpu_rw_n;
  logic [23:1]         cpu_adr;
  logic                rom_sel;
  logic                flush;
  logic                dtack_n;
  logic [15:0]         dout;
  logic                req;
  logic [20:0]         req_addr;
  logic                ack_async;
  logic [63:0]         line_data;
  logic [TB_CNT_W-1:0] hit_count;
  logic [TB_CNT_W-1:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  pgm_rom_fetch_ctrl #(.IDX_W(2), .CNT_W(TB_CNT_W)) dut (
    .fixed_20m_clk (fixed_20m_clk),
    .reset         (reset),
    .cpu_as_n      (cpu_as_n),
    .cpu_rw_n      (cpu_rw_n),
    .cpu_adr       (cpu_adr),
    .rom_sel       (rom_sel),
    .flush         (flush),
    .dtack_n       (dtack_n),
    .dout          (dout),
    .req           (req),
    .req_addr      (req_addr),
    .ack_async     (ack_async),
    .line_data     (line_data),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  initial fixed_20m_clk = 1'b0;
  always #25 fixed_20m_clk = ~fixed_20m_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2 ms, required to finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fixed_20m_clk);
    #1;
  endtask

  task automatic cpu_start(input logic [23:0] a, input logic rd);
    cpu_adr  = a[23:1];
    cpu_rw_n = rd;
    rom_sel  = 1'b1;
    cpu_as_n = 1'b0;
  endtask

  task automatic cpu_end();
    cpu_as_n = 1'b1;
    rom_sel  = 1'b0;
    cpu_rw_n = 1'b1;
  endtask

  // Read miss with a zero-delay arbiter. flush_at: 0 none, 1 while REQ
  // waits for ack, 2 in the same cycle the synchronised ack is seen.
  task automatic miss_read(input string tag, input logic [23:0] a, input logic [63:0] line,
                           input logic [15:0] exp_word, input int flush_at);
    cpu_start(a, 1'b1);
    tick();
    check({tag, " req"}, req, 1);
    check({tag, " req_addr"}, req_addr, a[23:3]);
    check({tag, " dtack_n early"}, dtack_n, 1);
    line_data = line;
    ack_async = 1'b1;
    if (flush_at == 1) flush = 1'b1;
    tick();
    flush = 1'b0;
    check({tag, " dtack_n sync1"}, dtack_n, 1);
    tick();
    if (flush_at == 2) flush = 1'b1;
    check({tag, " req held"}, req, 1);
    check({tag, " dtack_n sync2"}, dtack_n, 1);
    tick();
    flush = 1'b0;
    check({tag, " dtack_n"}, dtack_n, 0);
    check({tag, " dout"}, dout, exp_word);
    check({tag, " req drop"}, req, 0);
    ack_async = 1'b0;
    line_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    tick();
    tick();
    check({tag, " dtack_n resp"}, dtack_n, 0);
    cpu_end();
    tick();
    check({tag, " dtack_n release"}, dtack_n, 1);
  endtask

  task automatic hit_read(input string tag, input logic [23:0] a, input logic [15:0] exp_word);
    cpu_start(a, 1'b1);
    tick();
    check({tag, " dtack_n"}, dtack_n, 0);
    check({tag, " dout"}, dout, exp_word);
    check({tag, " no req"}, req, 0);
    cpu_end();
    tick();
    check({tag, " dtack_n release"}, dtack_n, 1);
  endtask

  localparam logic [63:0] L1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] L2 = 64'hDDDD_CCCC_BBBB_AAAA;
  localparam logic [63:0] L3 = 64'h8888_7777_6666_5555;
  localparam logic [63:0] L4 = 64'h7654_3210_0123_4567;

  initial begin
    reset     = 1'b1;
    cpu_as_n  = 1'b1;
    cpu_rw_n  = 1'b1;
    cpu_adr   = '0;
    rom_sel   = 1'b0;
    flush     = 1'b0;
    ack_async = 1'b1;
    line_data = '0;

    // Reset with an open handshake (ack high)
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset req", req, 0);
    end
    check("reset dtack_n", dtack_n, 1);
    check("reset dout", dout, 16'hFFFF);
    check("reset req_addr", req_addr, 0);
    check("reset hit_count", hit_count, 0);
    check("reset miss_count", miss_count, 0);

    // Out of reset, ack still high: a ROM read must not start a request
    reset = 1'b0;
    cpu_start(24'h100000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("drain req", req, 0);
      check("drain dtack_n", dtack_n, 1);
    end
    cpu_end();
    tick();
    ack_async = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain exit req", req, 0);
    end

    // Cold miss, then hits on the same line
    miss_read("m1", 24'h100000, L1, 16'h1111, 0);
    check("m1 miss_count", miss_count, 1);
    check("m1 hit_count", hit_count, 0);
    hit_read("h1", 24'h100002, 16'h2222);
    hit_read("h2", 24'h100004, 16'h3333);
    hit_read("h3", 24'h100006, 16'h4444);
    check("h hit_count", hit_count, 3);
    check("h miss_count", miss_count, 1);

    // Same index, different tag: evict, then refetch the original line
    miss_read("m2", 24'h100020, L2, 16'hAAAA, 0);
    miss_read("m3", 24'h100000, L1, 16'h1111, 0);
    check("m3 miss_count", miss_count, 3);

    // Flush in the ack cycle, then flush while waiting: both fills stay invalid
    miss_read("f1", 24'h200008, L3, 16'h5555, 2);
    miss_read("f2", 24'h200008, L3, 16'h5555, 1);
    miss_read("f3", 24'h200008, L3, 16'h5555, 0);
    hit_read("f4", 24'h20000E, 16'h8888);
    miss_read("f5", 24'h100000, L1, 16'h1111, 0);
    check("f miss_count", miss_count, 7);
    check("f hit_count", hit_count, 4);

    // Abort: AS drops while the request is outstanding
    cpu_start(24'h300012, 1'b1);
    tick();
    check("ab req", req, 1);
    check("ab req_addr", req_addr, 21'h060002);
    cpu_end();
    line_data = L4;
    ack_async = 1'b1;
    tick();
    check("ab dtack_n 1", dtack_n, 1);
    check("ab req 1", req, 1);
    tick();
    check("ab dtack_n 2", dtack_n, 1);
    check("ab req 2", req, 1);
    tick();
    check("ab dtack_n 3", dtack_n, 1);
    check("ab req drop", req, 0);
    // New read while the aborted handshake is still closing
    cpu_start(24'h300012, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab wait ack dtack_n", dtack_n, 1);
    end
    ack_async = 1'b0;
    line_data = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab ack falling dtack_n", dtack_n, 1);
    end
    tick();
    check("ab next dtack_n", dtack_n, 0);
    check("ab next dout", dout, 16'h0123);
    check("ab next req", req, 0);
    cpu_end();
    tick();
    check("ab next release", dtack_n, 1);
    check("ab miss_count", miss_count, 8);
    check("ab hit_count", hit_count, 5);

    // Write cycle: immediate DTACK, no request, counters untouched
    cpu_start(24'h100000, 1'b0);
    tick();
    check("wr dtack_n", dtack_n, 0);
    check("wr req", req, 0);
    cpu_end();
    tick();
    check("wr release", dtack_n, 1);
    check("wr hit_count", hit_count, 5);
    check("wr miss_count", miss_count, 8);

    // Saturation: 12 more hits from 5 must stop at 15, not wrap
    for (int i = 0; i < 12; i++) hit_read("sat", 24'h100004, 16'h3333);
    check("sat hit_count", hit_count, 15);
    check("sat miss_count", miss_count, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
